// File: rtl/serial_addsub_ctrl_pkg.sv
// addsub_pkg: shared states, slice width and opcode encodings
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// serial_addsub_ctrl_if: start/busy/done handshake and operand/result bus
interface serial_addsub_ctrl_if #(parameter int NIBBLES = 4);
  logic                 start;
  logic                 op;
  logic [4*NIBBLES-1:0] a;
  logic [4*NIBBLES-1:0] b;
  logic                 busy;
  logic                 done;
  logic [4*NIBBLES-1:0] result;
  logic                 cout;
  logic                 overflow;
  logic                 zero;
  modport master (output start, op, a, b, input busy, done, result, cout, overflow, zero);
  modport slave  (input start, op, a, b, output busy, done, result, cout, overflow, zero);
endinterface

// File: rtl/serial_addsub_ctrl_nibble.sv
// nibble_addsub: 4-bit add slice with optional B inversion, exposing carry into bit 3
module nibble_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       inv,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);
  logic [3:0] bb;
  logic [4:0] sum;
  logic [3:0] lo;
  assign bb = b ^ {4{inv}};
  assign sum = {1'b0, a} + {1'b0, bb} + {4'b0, cin};
  assign lo = {1'b0, a[2:0]} + {1'b0, bb[2:0]} + {3'b0, cin};
  assign s = sum[3:0];
  assign cout = sum[4];
  assign c3 = lo[3];
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: nibble-serial multi-precision add/subtract sequencer
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic reset,
  serial_addsub_ctrl_if.slave bus
);
  localparam int W = NIBBLE_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  state_t state;
  logic [W-1:0] a_q, b_q, res_q, res_nx;
  logic [IW-1:0] idx;
  logic op_q, carry_q, busy_q, done_q, cout_q, ovf_q, zero_q;
  logic [3:0] s;
  logic co, c3;
  nibble_addsub u_slice (
    .a   (a_q[{idx, 2'b00} +: NIBBLE_W]),
    .b   (b_q[{idx, 2'b00} +: NIBBLE_W]),
    .inv (op_q),
    .cin (carry_q),
    .s   (s),
    .cout(co),
    .c3  (c3)
  );
  // result with the current slice output merged in, so zero sees the final nibble
  always_comb begin
    res_nx = res_q;
    res_nx[{idx, 2'b00} +: NIBBLE_W] = s;
  end
  // sequencer: accept, step one nibble per cycle, pulse done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      carry_q <= 1'b0;
      idx <= '0;
      res_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q <= bus.a;
          b_q <= bus.b;
          op_q <= bus.op;
          carry_q <= bus.op;
          idx <= '0;
          res_q <= '0;
          busy_q <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          res_q <= res_nx;
          carry_q <= co;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            cout_q <= co;
            ovf_q <= co ^ c3;
            zero_q <= res_nx == '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.result = res_q;
  assign bus.cout = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: directed self-checking bench for the serial add/sub sequencer
module tb_serial_addsub_ctrl;
  import addsub_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc, bcnt, dcnt, last_done;
  always #5 clk = ~clk;
  serial_addsub_ctrl_if #(.NIBBLES(4)) bus ();
  serial_addsub_ctrl #(.NIBBLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drives one start at a negedge; optionally pulses a bogus start during RUN; waits for done
  task automatic do_op(input logic op, input logic [15:0] a, input logic [15:0] b, input bit poke,
                       output int cycles, output int busy_cnt);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    cycles = 0; busy_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      cycles++;
      bus.start = 1'b0;
      bus.a = ~a; bus.b = a ^ b; bus.op = ~op;
      if (poke && cycles == 2) bus.start = 1'b1;
      if (bus.busy) busy_cnt++;
      if (bus.done) break;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = OP_ADD; bus.a = '0; bus.b = '0;
    #1;
    chk("reset_busy", {31'b0, bus.busy}, 0);
    chk("reset_done", {31'b0, bus.done}, 0);
    chk("reset_result", {16'b0, bus.result}, 0);
    chk("reset_flags", {29'b0, bus.cout, bus.overflow, bus.zero}, 0);
    @(negedge clk); reset = 1'b0;

    do_op(OP_ADD, 16'h1234, 16'h0FFF, 0, cyc, bcnt);
    chk("add1_latency", cyc, 5);
    chk("add1_busy_cycles", bcnt, 4);
    chk("add1_result", {16'b0, bus.result}, 32'h2233);
    chk("add1_flags", {29'b0, bus.cout, bus.overflow, bus.zero}, 3'b000);
    @(negedge clk);
    chk("add1_done_pulse", {31'b0, bus.done}, 0);
    chk("add1_result_hold", {16'b0, bus.result}, 32'h2233);

    do_op(OP_SUB, 16'h0000, 16'h0001, 0, cyc, bcnt);
    chk("sub_borrow_result", {16'b0, bus.result}, 32'hFFFF);
    chk("sub_borrow_flags", {29'b0, bus.cout, bus.overflow, bus.zero}, 3'b000);

    do_op(OP_ADD, 16'hFFFF, 16'h0001, 0, cyc, bcnt);
    chk("add_wrap_result", {16'b0, bus.result}, 0);
    chk("add_wrap_flags", {29'b0, bus.cout, bus.overflow, bus.zero}, 3'b101);

    do_op(OP_ADD, 16'h7FFF, 16'h0001, 0, cyc, bcnt);
    chk("add_ovf_result", {16'b0, bus.result}, 32'h8000);
    chk("add_ovf_flags", {29'b0, bus.cout, bus.overflow, bus.zero}, 3'b010);

    do_op(OP_SUB, 16'h8000, 16'h8000, 0, cyc, bcnt);
    chk("sub_eq_result", {16'b0, bus.result}, 0);
    chk("sub_eq_flags", {29'b0, bus.cout, bus.overflow, bus.zero}, 3'b101);

    do_op(OP_ADD, 16'h0102, 16'h0304, 1, cyc, bcnt);
    chk("ignore_latency", cyc, 5);
    chk("ignore_result", {16'b0, bus.result}, 32'h0406);
    dcnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("ignore_no_extra_done", dcnt, 0);
    chk("ignore_result_hold", {16'b0, bus.result}, 32'h0406);

    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 16'h1111; bus.b = 16'h2222;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", {31'b0, bus.busy}, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, bus.busy}, 0);
    chk("abort_done", {31'b0, bus.done}, 0);
    chk("abort_result", {16'b0, bus.result}, 0);
    chk("abort_flags", {29'b0, bus.cout, bus.overflow, bus.zero}, 0);
    @(negedge clk); reset = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    do_op(OP_ADD, 16'h0001, 16'h0001, 0, cyc, bcnt);
    chk("after_abort_result", {16'b0, bus.result}, 32'h0002);
    chk("after_abort_latency", cyc, 5);

    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 16'h0003; bus.b = 16'h0004;
    dcnt = 0; last_done = -1;
    for (int n = 0; n < 26; n++) begin
      @(negedge clk);
      if (last_done >= 0 && n == last_done + 1) begin
        chk("b2b_done_pulse", {31'b0, bus.done}, 0);
        chk("b2b_result_hold", {16'b0, bus.result}, 32'h0007);
      end
      if (bus.done) begin
        chk("b2b_result", {16'b0, bus.result}, 32'h0007);
        if (last_done >= 0) chk("b2b_period", n - last_done, 6);
        last_done = n;
        dcnt++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_done_count", dcnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Multi-precision add/subtract sequencer that computes a WIDTH-bit (4·NIBBLES) sum or difference over one 4-bit add/sub slice. It processes one nibble per clock, least significant first, and carries between cycles in a register. It sits beside the 4-bit adder/subtractor datapath and lets lab-level designs do 16-bit arithmetic without a wide ripple chain. It uses a start/busy/done handshake.

## Interface
Parameters:
- NIBBLES, 4: number of 4-bit slices; operand width W = 4·NIBBLES; legal range 2..8.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = add (A+B), 1 = subtract (A−B); latched with start.
- a  in  W  operand A; latched with start.
- b  in  W  operand B; latched with start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result and flags are valid.
- result  out  W  sum/difference; holds until the next accepted start.
- cout  out  1  carry out of MSB; on subtract, 1 = no borrow (a ≥ b unsigned).
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  out  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch a, b, op into operand registers.
  - carry_q ← op.
  - idx ← 0.
  - clear result to 0.
  - go to RUN.
- RUN, each cycle:
  - slice inputs: A = a_q[4·idx+3:4·idx], B = b_q nibble XOR {4{op_q}}, cin = carry_q.
  - result nibble idx ← S; carry_q ← slice cout; idx ← idx+1.
  - on idx = NIBBLES−1: also register cout, overflow (from the slice's internal carry into bit 3), and zero (evaluated on the complete result including the new nibble); go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE; it is not queued.
- Inputs a, b, op may change freely after the start cycle.
- result is visible nibble-by-nibble during RUN and is valid only when done=1 or afterwards.
- Reset: state=IDLE; busy, done, cout, overflow, zero = 0; result = 0; idx = 0; carry_q = 0.
- Reset mid-operation aborts immediately; no done pulse; the partial result is cleared.
- Arithmetic is modulo 2^W; no saturation.

## Timing
- Start accepted at edge k: busy=1 from after edge k through edge k+NIBBLES.
- done=1 in the cycle after edge k+NIBBLES.
- IDLE again after edge k+NIBBLES+1.
- Latency start→done = NIBBLES+1 cycles (5 for default).
- Throughput: one operation per NIBBLES+2 cycles.
- Back-to-back: a start held high through DONE is accepted at the first IDLE edge.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `addsub_pkg`:
  - state_t enum {IDLE, RUN, DONE}
  - NIBBLE_W = 4
  - OP_ADD = 1'b0, OP_SUB = 1'b1
- Sub-module `nibble_addsub`:
  - 4-bit ripple slice with explicit cin (not tied to op), B-inversion input, and outputs S, cout, c3 (carry into bit 3).
  - Instantiated once.
- Controller: state register, idx counter ($clog2(NIBBLES) bits), carry_q, operand and result registers, flag registers.

## Test plan
- add 0x1234 + 0x0FFF → result 0x2233, cout 0, overflow 0, zero 0; done exactly 5 cycles after start; busy high for 4 cycles.
- sub 0x0000 − 0x0001 → 0xFFFF, cout 0 (borrow), overflow 0; add 0xFFFF + 0x0001 → 0x0000, cout 1, zero 1.
- add 0x7FFF + 0x0001 → 0x8000, overflow 1, cout 0; sub 0x8000 − 0x8000 → 0x0000, zero 1, cout 1, overflow 0.
- start pulsed during RUN with different a/b/op → ignored; first result unchanged; single done pulse.
- reset asserted in 2nd RUN cycle → busy, done, result, flags 0 asynchronously; no done follows; next start 0x0001 + 0x0001 → 0x0002.
- start held high continuously → operations repeat every 6 cycles; each done is a 1-cycle pulse; result stable between done and the next accepted start.
